uart_frame_tx: RTL and testbench

Serial transmit engine for the ALU response path. It accepts one multi-byte result word through a valid/ready handshake. It sends the word on sci_tx as a burst of back-to-back 8N1 UART characters, least-significant byte first, each character LSB first. It sits between the ALU result register and the sci_tx pin of uart_alu_top, and mirrors the byte format the host uses on sci_rx.

---
 rtl/uart_frame_tx.sv | 147 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends a NUM_BYTES-wide result word as a burst of back-to-back
// 8N1 characters on sci_tx, least-significant byte first, each character LSB first.
module uart_frame_tx #(
   parameter int unsigned CLK_PER_BIT = 5208,
   parameter int unsigned NUM_BYTES   = 3,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [8*NUM_BYTES-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   sci_tx,
   output logic                   busy,
   output logic                   tx_done
);

   localparam int unsigned     CNT_W     = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [2:0]       LAST_BYTE = 3'(NUM_BYTES - 1);
   localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             byte_cnt_q, byte_cnt_d;
   logic [8*NUM_BYTES-1:0] frame_q, frame_d;
   logic [7:0]             shreg_q, shreg_d;
   logic                   sci_tx_q, sci_tx_d;
   logic                   in_ready_q, in_ready_d;
   logic                   busy_q, busy_d;
   logic                   tx_done_q, tx_done_d;
   logic                   accept;
   logic                   bit_end;
   logic                   final_cycle_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      frame_d    = frame_q;
      shreg_d    = shreg_q;
      accept     = in_valid && in_ready_q;
      bit_end    = (cnt_q == CNT_MAX);

      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = START;
               cnt_d      = '0;
               byte_cnt_d = '0;
               frame_d    = in_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               shreg_d   = frame_q[7:0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d   = STOP;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt_q != LAST_STOP) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end else if (byte_cnt_q != LAST_BYTE) begin
                  state_d    = START;
                  byte_cnt_d = byte_cnt_q + 3'd1;
                  frame_d    = frame_q >> 8;
               end else if (accept) begin
                  // next word taken in the final stop cycle: no idle gap
                  state_d    = START;
                  byte_cnt_d = '0;
                  frame_d    = in_data;
               end else begin
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   // Outputs are registered from next-state values; the final stop cycle is
   // known one edge ahead, so tx_done/in_ready line up with the STOP exit edge.
   always_comb begin
      final_cycle_d = (state_d == STOP) && (bit_cnt_d == LAST_STOP) &&
                      (byte_cnt_d == LAST_BYTE) && (cnt_d == CNT_MAX);
      in_ready_d    = (state_d == IDLE) || final_cycle_d;
      tx_done_d     = final_cycle_d;
      busy_d        = (state_d != IDLE);
      case (state_d)
         START:   sci_tx_d = 1'b0;
         DATA:    sci_tx_d = shreg_d[0];
         default: sci_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         frame_q    <= '0;
         shreg_q    <= '0;
         sci_tx_q   <= 1'b1;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         frame_q    <= frame_d;
         shreg_q    <= shreg_d;
         sci_tx_q   <= sci_tx_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign in_ready = in_ready_q;
   assign sci_tx   = sci_tx_q;
   assign busy     = busy_q;
   assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: table of result words plus hand-written
// back-to-back, reset-mid-frame, two-stop-bit and default-baud sequences.
module tb_uart_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic        a_rst_n, a_in_valid, a_in_ready, a_sci_tx, a_busy, a_tx_done;
   logic [23:0] a_in_data;
   logic        b_rst_n, b_in_valid, b_in_ready, b_sci_tx, b_busy, b_tx_done;
   logic [23:0] b_in_data;
   logic        c_rst_n, c_in_valid, c_in_ready, c_sci_tx, c_busy, c_tx_done;
   logic [23:0] c_in_data;

   uart_frame_tx #(.CLK_PER_BIT(16), .NUM_BYTES(3), .STOP_BITS(1)) u_a (
      .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .sci_tx(a_sci_tx), .busy(a_busy), .tx_done(a_tx_done));

   uart_frame_tx #(.CLK_PER_BIT(16), .NUM_BYTES(3), .STOP_BITS(2)) u_b (
      .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .sci_tx(b_sci_tx), .busy(b_busy), .tx_done(b_tx_done));

   uart_frame_tx u_c (
      .clk(clk), .rst_n(c_rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .sci_tx(c_sci_tx), .busy(c_busy), .tx_done(c_tx_done));

   typedef struct {
      logic [23:0] word;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;
   vec_t vecs [4];

   logic cap_tx   [0:1199];
   logic cap_done [0:1199];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic send(input bit use_b, input logic [23:0] w, input string tag);
      int waitc;
      waitc = 0;
      if (use_b) begin b_in_data = w; b_in_valid = 1'b1; end
      else       begin a_in_data = w; a_in_valid = 1'b1; end
      while ((use_b ? b_in_ready : a_in_ready) !== 1'b1 && waitc < 2000) begin
         @(negedge clk);
         waitc++;
      end
      check($sformatf("%s accept wait", tag), 32'(waitc < 2000), 32'd1);
      @(negedge clk);
      if (use_b) begin b_in_valid = 1'b0; b_in_data = ~w; end
      else       begin a_in_valid = 1'b0; a_in_data = ~w; end
      check($sformatf("%s start latency", tag), use_b ? b_sci_tx : a_sci_tx, 32'd0);
      check($sformatf("%s busy after accept", tag), use_b ? b_busy : a_busy, 32'd1);
      check($sformatf("%s in_ready after accept", tag), use_b ? b_in_ready : a_in_ready, 32'd0);
   endtask

   task automatic capture(input bit use_b, input int n);
      for (int i = 0; i < n; i++) begin
         cap_tx[i]   = use_b ? b_sci_tx : a_sci_tx;
         cap_done[i] = use_b ? b_tx_done : a_tx_done;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input int off, input int nstop, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input bit tail, input string tag);
      logic [7:0] eb [3];
      logic [7:0] got;
      logic       ok;
      int         base, len, first, pulses;
      eb[0] = e0; eb[1] = e1; eb[2] = e2;
      got = '0;
      len = 3 * (9 + nstop) * 16;
      for (int k = 0; k < 3; k++) begin
         base = off + k * (9 + nstop) * 16;
         ok = 1'b1;
         for (int j = 0; j < 16; j++) if (cap_tx[base + j] !== 1'b0) ok = 1'b0;
         check($sformatf("%s byte%0d start bit", tag, k), ok, 32'd1);
         ok = 1'b1;
         for (int i = 0; i < 8; i++) begin
            got[i] = cap_tx[base + (1 + i) * 16 + 8];
            for (int j = 0; j < 16; j++)
               if (cap_tx[base + (1 + i) * 16 + j] !== eb[k][i]) ok = 1'b0;
         end
         check($sformatf("%s byte%0d decode", tag, k), got, eb[k]);
         check($sformatf("%s byte%0d bit timing", tag, k), ok, 32'd1);
         ok = 1'b1;
         for (int j = 0; j < nstop * 16; j++) if (cap_tx[base + 144 + j] !== 1'b1) ok = 1'b0;
         check($sformatf("%s byte%0d stop interval", tag, k), ok, 32'd1);
      end
      first = -1;
      pulses = 0;
      for (int j = off; j < off + len; j++) begin
         if (cap_done[j] === 1'b1) begin
            pulses++;
            if (first < 0) first = j - off;
         end
      end
      // tx_done occupies the last cycle of the frame: cycle number len, index len-1
      check($sformatf("%s tx_done position", tag), first, len - 1);
      check($sformatf("%s tx_done pulses", tag), pulses, 32'd1);
      if (tail) begin
         ok = 1'b1;
         for (int j = off + len; j < off + len + 20; j++)
            if (cap_tx[j] !== 1'b1 || cap_done[j] !== 1'b0) ok = 1'b0;
         check($sformatf("%s idle after frame", tag), ok, 32'd1);
      end
   endtask

   task automatic slow_c();
      logic [9:0] lvl;
      logic [7:0] got;
      logic       ok;
      int         waitc;
      int         cpb;
      cpb = 5208;
      lvl = 10'b1_1010_0101_0;
      got = '0;
      waitc = 0;
      c_in_data = 24'h0106A5;
      c_in_valid = 1'b1;
      while (c_in_ready !== 1'b1 && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check("c accept wait", 32'(waitc < 100), 32'd1);
      @(negedge clk);
      c_in_valid = 1'b0;
      for (int p = 0; p < 10; p++) begin
         ok = 1'b1;
         for (int j = 0; j < cpb; j++) begin
            if (c_sci_tx !== lvl[p]) ok = 1'b0;
            if (p >= 1 && p <= 8 && j == cpb / 2) got[p - 1] = c_sci_tx;
            @(negedge clk);
         end
         check($sformatf("c bit%0d held 5208 cycles", p), ok, 32'd1);
      end
      check("c byte0 decode", got, 32'h0000_00A5);
      check("c byte1 start follows stop", c_sci_tx, 32'd0);
      c_rst_n = 1'b0;
   endtask

   task automatic fast_tests();
      logic ok_tx, ok_rdy, ok_busy, ok_done;
      int   pulses;

      ok_tx = 1'b1; ok_rdy = 1'b1; ok_busy = 1'b1; ok_done = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_sci_tx !== 1'b1)   ok_tx   = 1'b0;
         if (a_in_ready !== 1'b1) ok_rdy  = 1'b0;
         if (a_busy !== 1'b0)     ok_busy = 1'b0;
         if (a_tx_done !== 1'b0)  ok_done = 1'b0;
      end
      check("idle sci_tx", ok_tx, 32'd1);
      check("idle in_ready", ok_rdy, 32'd1);
      check("idle busy", ok_busy, 32'd1);
      check("idle tx_done", ok_done, 32'd1);

      for (int v = 0; v < 4; v++) begin
         send(1'b0, vecs[v].word, $sformatf("vec%0d", v));
         capture(1'b0, 500);
         check_frame(0, 1, vecs[v].b0, vecs[v].b1, vecs[v].b2, 1'b1, $sformatf("vec%0d", v));
      end

      a_in_data = 24'h123456;
      a_in_valid = 1'b1;
      while (a_in_ready !== 1'b1) @(negedge clk);
      @(negedge clk);
      a_in_data = 24'hABCDEF;
      for (int i = 0; i < 980; i++) begin
         cap_tx[i]   = a_sci_tx;
         cap_done[i] = a_tx_done;
         @(negedge clk);
         if (cap_done[i] === 1'b1) a_in_valid = 1'b0;
      end
      check_frame(0, 1, 8'h56, 8'h34, 8'h12, 1'b0, "b2b first");
      check_frame(480, 1, 8'hEF, 8'hCD, 8'hAB, 1'b1, "b2b second");
      pulses = 0;
      for (int i = 0; i < 980; i++) if (cap_done[i] === 1'b1) pulses++;
      check("b2b total tx_done", pulses, 32'd2);

      send(1'b0, 24'h000000, "rst");
      repeat (200) @(negedge clk);
      check("rst line low before reset", a_sci_tx, 32'd0);
      #2 a_rst_n = 1'b0;
      #1;
      check("rst sci_tx async", a_sci_tx, 32'd1);
      check("rst busy async", a_busy, 32'd0);
      check("rst in_ready async", a_in_ready, 32'd1);
      repeat (3) @(negedge clk);
      a_rst_n = 1'b1;
      ok_tx = 1'b1; ok_busy = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (a_sci_tx !== 1'b1) ok_tx = 1'b0;
         if (a_busy !== 1'b0)   ok_busy = 1'b0;
      end
      check("after reset line quiet", ok_tx, 32'd1);
      check("after reset not busy", ok_busy, 32'd1);

      send(1'b1, 24'hFF00FF, "stop2");
      capture(1'b1, 548);
      check_frame(0, 2, 8'hFF, 8'h00, 8'hFF, 1'b1, "stop2");
   endtask

   initial begin
      vecs[0] = '{24'h000059, 8'h59, 8'h00, 8'h00};
      vecs[1] = '{24'h123456, 8'h56, 8'h34, 8'h12};
      vecs[2] = '{24'hABCDEF, 8'hEF, 8'hCD, 8'hAB};
      vecs[3] = '{24'h8001FF, 8'hFF, 8'h01, 8'h80};

      a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
      a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
      a_in_data = '0; b_in_data = '0; c_in_data = '0;
      repeat (10) @(negedge clk);
      check("reset sci_tx", a_sci_tx, 32'd1);
      check("reset in_ready", a_in_ready, 32'd1);
      check("reset busy", a_busy, 32'd0);
      check("reset tx_done", a_tx_done, 32'd0);
      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

      fork
         slow_c();
         fast_tests();
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
